// File: rtl/modular_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : modular_addsub_pipe
//  Description : Multi-lane modular add/subtract, 2-stage valid/ready pipeline
//                with bubble collapsing and a pass-through sideband tag.
//  Revision    : 1.0 - initial release
// ============================================================================
module modular_addsub_pipe #(
    parameter int              WIDTH = 30,
    parameter longint unsigned Q     = 64'd1073479681,
    parameter int              LANES = 1,
    parameter int              TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_c,
    output logic [TAG_W-1:0]       out_tag,
    output logic [LANES-1:0]       out_err
);

    localparam logic [WIDTH:0]   c_Q          = Q[WIDTH:0];
    localparam logic [WIDTH-1:0] c_QW         = Q[WIDTH-1:0];
    localparam int               c_RAW_W      = WIDTH + 1;
    localparam bit               c_PARAM_OK   = (Q >= 64'd2) && (Q < (64'd1 << WIDTH));

    // Stage 1 registers
    logic                       r_v1;
    logic                       r_mode1;
    logic [TAG_W-1:0]           r_tag1;
    logic [LANES*c_RAW_W-1:0]   r_raw1;
    logic [LANES-1:0]           r_err1;

    // Stage 2 registers (drive the outputs directly)
    logic                       r_v2;
    logic [LANES*WIDTH-1:0]     r_c2;
    logic [TAG_W-1:0]           r_tag2;
    logic [LANES-1:0]           r_err2;

    logic                       w_en1;
    logic                       w_en2;
    logic [LANES*c_RAW_W-1:0]   w_raw_in;
    logic [LANES-1:0]           w_err_in;
    logic [LANES*WIDTH-1:0]     w_c_out;

    // S1 may refill whenever its contents are guaranteed to move on this cycle
    assign w_en2    = !r_v2 || out_ready;
    assign w_en1    = !r_v1 || w_en2;
    assign in_ready = w_en1;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [WIDTH-1:0] w_a;
        logic [WIDTH-1:0] w_b;
        logic [WIDTH:0]   w_sum;
        logic [WIDTH:0]   w_diff;
        logic [WIDTH:0]   w_raw1;
        logic [WIDTH-1:0] w_c;

        assign w_a    = in_a[i*WIDTH +: WIDTH];
        assign w_b    = in_b[i*WIDTH +: WIDTH];
        assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
        assign w_diff = {1'b0, w_a} - {1'b0, w_b};

        assign w_raw_in[i*c_RAW_W +: c_RAW_W] = in_mode ? w_diff : w_sum;
        assign w_err_in[i] = ({1'b0, w_a} >= c_Q) || ({1'b0, w_b} >= c_Q);

        assign w_raw1 = r_raw1[i*c_RAW_W +: c_RAW_W];

        // Single correction step; the sign bit of raw marks a negative difference
        always_comb begin
            w_c = w_raw1[WIDTH-1:0];
            if (r_mode1) begin
                if (w_raw1[WIDTH]) begin
                    w_c = w_raw1[WIDTH-1:0] + c_QW;
                end
            end else begin
                if (w_raw1 >= c_Q) begin
                    w_c = w_raw1[WIDTH-1:0] - c_QW;
                end
            end
        end

        assign w_c_out[i*WIDTH +: WIDTH] = w_c;

        a_lane_in_range : assert property (@(posedge clk) disable iff (rst)
            !out_err[i] |-> (out_c[i*WIDTH +: WIDTH] < c_QW));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_mode1 <= 1'b0;
            r_tag1  <= '0;
            r_raw1  <= '0;
            r_err1  <= '0;
            r_v2    <= 1'b0;
            r_c2    <= '0;
            r_tag2  <= '0;
            r_err2  <= '0;
        end else begin
            if (w_en1) begin
                r_v1    <= in_valid;
                r_mode1 <= in_mode;
                r_tag1  <= in_tag;
                r_raw1  <= w_raw_in;
                r_err1  <= w_err_in;
            end
            if (w_en2) begin
                r_v2   <= r_v1;
                r_c2   <= w_c_out;
                r_tag2 <= r_tag1;
                r_err2 <= r_err1;
            end
        end
    end

    assign out_valid = r_v2;
    assign out_c     = r_c2;
    assign out_tag   = r_tag2;
    assign out_err   = r_err2;

    a_param_ok : assert property (@(posedge clk) c_PARAM_OK);

    a_out_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_c) && $stable(out_tag) && $stable(out_err)));

endmodule
`default_nettype wire

// File: tb/tb_modular_addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_modular_addsub_pipe
//  Description : Self-checking bench for modular_addsub_pipe (4 lanes).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_modular_addsub_pipe;

    localparam int     W  = 30;
    localparam longint Q  = 64'd1073479681;
    localparam int     L  = 4;
    localparam int     TW = 8;
    localparam int     LW = L * W;

    typedef struct packed {
        logic [LW-1:0] c;
        logic [TW-1:0] tag;
        logic [L-1:0]  err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [LW-1:0] in_a;
    logic [LW-1:0] in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_c;
    logic [TW-1:0] out_tag;
    logic [L-1:0]  out_err;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    modular_addsub_pipe #(
        .WIDTH(W), .Q(Q), .LANES(L), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_tag(out_tag), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: modular result from plain integer arithmetic, one correction
    function automatic exp_t model(input bit m, input logic [LW-1:0] a,
                                   input logic [LW-1:0] b, input logic [TW-1:0] tag);
        exp_t e;
        e.c   = '0;
        e.err = '0;
        e.tag = tag;
        for (int l = 0; l < L; l++) begin
            longint x, y, r;
            x = 0;
            y = 0;
            x[W-1:0] = a[l*W +: W];
            y[W-1:0] = b[l*W +: W];
            if (!m) begin
                r = x + y;
                if (r >= Q) r = r - Q;
            end else begin
                r = x - y;
                if (r < 0) r = r + Q;
            end
            e.c[l*W +: W] = r[W-1:0];
            e.err[l]      = (x >= Q) || (y >= Q);
        end
        return e;
    endfunction

    function automatic logic [LW-1:0] rand_opnd(input bit allow_oor);
        logic [LW-1:0] v;
        longint t;
        int sel;
        v = '0;
        for (int l = 0; l < L; l++) begin
            sel = int'($urandom_range(0, 15));
            if (allow_oor && sel == 0)  t = Q + longint'($urandom_range(0, 262142));
            else if (sel == 1)          t = Q - 1;
            else if (sel == 2)          t = 0;
            else                        t = longint'($urandom_range(0, 32'(Q - 1)));
            v[l*W +: W] = t[W-1:0];
        end
        return v;
    endfunction

    // One clock cycle: drive after negedge, sample #1 later, then let posedge happen
    task automatic step(input bit v, input bit m, input logic [LW-1:0] a,
                        input logic [LW-1:0] b, input logic [TW-1:0] tag, input bit ordy,
                        output bit irdy, output bit acc, output bit ovld, output exp_t obs);
        @(negedge clk);
        in_valid  = v;
        in_mode   = m;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = ordy;
        #1;
        irdy      = in_ready;
        acc       = v && in_ready;
        ovld      = out_valid;
        obs.c     = out_c;
        obs.tag   = out_tag;
        obs.err   = out_err;
        if (acc) exp_q.push_back(model(m, a, b, tag));
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_a = '0; in_b = '0;
        in_tag = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_c !== '0)       begin errors++; $display("FAIL reset_out_c: got %h expected 0", out_c); end
        checks++; if (out_tag !== '0)     begin errors++; $display("FAIL reset_out_tag: got %h expected 0", out_tag); end
        checks++; if (out_err !== '0)     begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    endtask

    task automatic test_directed();
        bit     tm [7];
        longint ta [7];
        longint tbv[7];
        longint tc [7];
        bit     te [7];
        bit irdy, acc, ovld, got;
        exp_t obs, e;
        logic [LW-1:0] a, b;
        longint t;
        int lat;
        tm  = '{0, 0, 1, 1, 1, 0, 1};
        ta  = '{3, Q - 1, 5, 123456, Q - 1, Q, 0};
        tbv = '{4, Q - 1, 7, 123456, 0, 0, Q};
        tc  = '{7, 1073479679, 1073479679, 0, 1073479680, 0, 0};
        te  = '{0, 0, 0, 0, 0, 1, 1};
        for (int k = 0; k < 7; k++) begin
            a = rand_opnd(1'b0);
            b = rand_opnd(1'b0);
            t = ta[k];  a[W-1:0] = t[W-1:0];
            t = tbv[k]; b[W-1:0] = t[W-1:0];
            step(1'b1, tm[k], a, b, TW'(8'h20 + k), 1'b1, irdy, acc, ovld, obs);
            checks++; if (!acc) begin errors++; $display("FAIL dir_accept[%0d]: got in_ready=%b expected 1", k, irdy); end
            lat = 0;
            got = 1'b0;
            while (!got && lat < 8) begin
                step(1'b0, 1'b0, '0, '0, '0, 1'b1, irdy, acc, ovld, obs);
                lat++;
                if (ovld) got = 1'b1;
            end
            checks++; if (!got || lat != 2) begin errors++; $display("FAIL dir_latency[%0d]: got %0d cycles expected 2", k, lat); end
            if (got && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tc[k];
                checks++;
                if (obs.c[W-1:0] !== t[W-1:0] || obs.err[0] !== te[k]) begin
                    errors++;
                    $display("FAIL dir_lane0[%0d]: got c=%0d err=%b expected c=%0d err=%b", k, obs.c[W-1:0], obs.err[0], t, te[k]);
                end
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL dir_all_lanes[%0d]: got c=%h tag=%h err=%b expected c=%h tag=%h err=%b",
                             k, obs.c, obs.tag, obs.err, e.c, e.tag, e.err);
                end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        bit irdy, acc, ovld, v;
        exp_t obs, e;
        int first, last, n;
        first = -1; last = -1; n = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            v = (cyc < 16);
            step(v, cyc[0], rand_opnd(1'b0), rand_opnd(1'b0), TW'(cyc), 1'b1, irdy, acc, ovld, obs);
            if (v) begin
                checks++; if (!acc) begin errors++; $display("FAIL b2b_accept[%0d]: got in_ready=%b expected 1", cyc, irdy); end
            end
            if (ovld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got tag=%h expected no output", obs.tag);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e || obs.tag !== TW'(n)) begin
                        errors++;
                        $display("FAIL b2b_result: got c=%h tag=%h err=%b expected c=%h tag=%h err=%b",
                                 obs.c, obs.tag, obs.err, e.c, TW'(n), e.err);
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
        end
        checks++; if (n != 16 || last - first != 15) begin errors++; $display("FAIL b2b_rate: got %0d results over %0d cycles expected 16 over 16", n, last - first + 1); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] pa[3], pb[3];
        bit irdy, acc, ovld, ordy, v;
        exp_t obs, e, held;
        int idx, n, first, last;
        idx = 0; n = 0; first = -1; last = -1; held = '0;
        for (int k = 0; k < 3; k++) begin
            pa[k] = rand_opnd(1'b0);
            pb[k] = rand_opnd(1'b0);
        end
        for (int cyc = 0; cyc < 16; cyc++) begin
            ordy = (cyc >= 6);
            v    = (idx < 3);
            step(v, (idx == 1), v ? pa[idx] : '0, v ? pb[idx] : '0, TW'(idx + 1), ordy,
                 irdy, acc, ovld, obs);
            if (cyc <= 2) begin
                checks++; if (acc !== (cyc < 2)) begin errors++; $display("FAIL bp_accept[%0d]: got %b expected %b", cyc, acc, (cyc < 2)); end
            end
            if (cyc == 2) held = obs;
            if (cyc >= 3 && cyc <= 5) begin
                checks++; if (irdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", cyc, irdy); end
                checks++;
                if (!ovld || obs !== held) begin
                    errors++;
                    $display("FAIL bp_stable[%0d]: got valid=%b c=%h tag=%h expected valid=1 c=%h tag=%h",
                             cyc, ovld, obs.c, obs.tag, held.c, held.tag);
                end
            end
            if (acc) idx++;
            if (ovld && ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bp_extra: got tag=%h expected no output", obs.tag);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e || obs.tag !== TW'(n + 1)) begin
                        errors++;
                        $display("FAIL bp_result: got c=%h tag=%h expected c=%h tag=%h", obs.c, obs.tag, e.c, TW'(n + 1));
                    end
                end
                if (first < 0) first = cyc;
                last = cyc;
                n++;
            end
        end
        checks++; if (n != 3 || last - first != 2) begin errors++; $display("FAIL bp_drain: got %0d results over %0d cycles expected 3 over 3", n, last - first + 1); end
        exp_q.delete();
    endtask

    task automatic test_bubble();
        bit irdy, acc, ovld, v, ordy;
        exp_t obs, e;
        int n;
        n = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            v    = (cyc == 0) || (cyc == 2);
            ordy = (cyc >= 5);
            step(v, cyc == 2, rand_opnd(1'b0), rand_opnd(1'b0), (cyc == 0) ? 8'hA0 : 8'hB0, ordy,
                 irdy, acc, ovld, obs);
            if (cyc == 0 || cyc == 2) begin
                checks++; if (!acc) begin errors++; $display("FAIL bubble_accept[%0d]: got %b expected 1", cyc, acc); end
            end
            if (cyc == 1) begin
                checks++; if (irdy !== 1'b1) begin errors++; $display("FAIL bubble_ready_gap: got %b expected 1", irdy); end
            end
            if (cyc == 3 || cyc == 4) begin
                checks++; if (irdy !== 1'b0) begin errors++; $display("FAIL bubble_full[%0d]: got %b expected 0", cyc, irdy); end
            end
            if (ovld && ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bubble_extra: got tag=%h expected no output", obs.tag);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL bubble_result: got c=%h tag=%h expected c=%h tag=%h", obs.c, obs.tag, e.c, e.tag);
                    end
                end
                n++;
            end
        end
        checks++; if (n != 2) begin errors++; $display("FAIL bubble_count: got %0d expected 2", n); end
        exp_q.delete();
    endtask

    task automatic test_random();
        bit irdy, acc, ovld, v, ordy, m, prev_stall, exp_rdy;
        exp_t obs, e, prev_obs;
        prev_stall = 1'b0; prev_obs = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            v    = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            m    = $urandom_range(0, 1) != 0;
            exp_rdy = (exp_q.size() < 2) || ordy;
            step(v, m, rand_opnd(1'b1), rand_opnd(1'b1), TW'($urandom), ordy, irdy, acc, ovld, obs);
            checks++; if (irdy !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", cyc, irdy, exp_rdy); end
            if (prev_stall) begin
                checks++;
                if (!ovld || obs !== prev_obs) begin
                    errors++;
                    $display("FAIL rnd_stable[%0d]: got valid=%b c=%h tag=%h expected valid=1 c=%h tag=%h",
                             cyc, ovld, obs.c, obs.tag, prev_obs.c, prev_obs.tag);
                end
            end
            if (ovld && ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra: got tag=%h expected no output", obs.tag);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL rnd_result[%0d]: got c=%h tag=%h err=%b expected c=%h tag=%h err=%b",
                                 cyc, obs.c, obs.tag, obs.err, e.c, e.tag, e.err);
                    end
                end
            end
            prev_stall = ovld && !ordy;
            prev_obs   = obs;
        end
        for (int cyc = 0; cyc < 6; cyc++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b1, irdy, acc, ovld, obs);
            if (ovld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_drain_extra: got tag=%h expected no output", obs.tag);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL rnd_drain: got c=%h tag=%h expected c=%h tag=%h", obs.c, obs.tag, e.c, e.tag);
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d missing results expected 0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_midflight();
        bit irdy, acc, ovld, got;
        exp_t obs, e;
        int lat;
        step(1'b1, 1'b0, rand_opnd(1'b0), rand_opnd(1'b0), 8'h11, 1'b0, irdy, acc, ovld, obs);
        checks++; if (!acc) begin errors++; $display("FAIL rst_fill0: got %b expected 1", acc); end
        step(1'b1, 1'b1, rand_opnd(1'b0), rand_opnd(1'b0), 8'h22, 1'b0, irdy, acc, ovld, obs);
        checks++; if (!acc) begin errors++; $display("FAIL rst_fill1: got %b expected 1", acc); end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        checks++; if (out_c !== '0)       begin errors++; $display("FAIL rst_mid_c: got %h expected 0", out_c); end
        checks++; if (out_tag !== '0)     begin errors++; $display("FAIL rst_mid_tag: got %h expected 0", out_tag); end
        rst = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 4; cyc++) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b1, irdy, acc, ovld, obs);
            checks++; if (ovld) begin errors++; $display("FAIL rst_stale[%0d]: got tag=%h expected no output", cyc, obs.tag); end
        end
        step(1'b1, 1'b0, rand_opnd(1'b0), rand_opnd(1'b0), 8'h33, 1'b1, irdy, acc, ovld, obs);
        lat = 0; got = 1'b0;
        while (!got && lat < 8) begin
            step(1'b0, 1'b0, '0, '0, '0, 1'b1, irdy, acc, ovld, obs);
            lat++;
            if (ovld) got = 1'b1;
        end
        checks++; if (!got || lat != 2) begin errors++; $display("FAIL rst_after_latency: got %0d cycles expected 2", lat); end
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL rst_after_result: got c=%h tag=%h expected c=%h tag=%h", obs.c, obs.tag, e.c, e.tag);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_bubble();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/modular_addsub_pipe.md
Name: modular_addsub_pipe

Overview:
Parametrised, multi-lane modular adder/subtractor for the NTT datapath. It computes (a + b) mod Q or (a - b) mod Q per lane, selected per transaction.
It is a 2-stage pipeline with valid/ready handshakes on both sides, bubble collapsing, and a sideband tag that passes through unchanged.
It sits between the coefficient memories and the butterfly/post-processing stages wherever a standalone modular add or subtract is needed under backpressure.

Parameters:
WIDTH, 30, operand/result bit width per lane
Q, 1073479681, modulus; must satisfy 2 <= Q < 2^WIDTH
LANES, 1, number of independent parallel lanes (>= 1)
TAG_W, 8, width of the pass-through sideband tag (>= 1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
in_mode  in  1  0 = add, 1 = subtract; applies to all lanes
in_a  in  LANES*WIDTH  operand a; lane i is bits [i*WIDTH +: WIDTH]
in_b  in  LANES*WIDTH  operand b; same lane packing
in_tag  in  TAG_W  sideband, returned unchanged with the result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_c  out  LANES*WIDTH  result; same lane packing
out_tag  out  TAG_W  tag of this result
out_err  out  LANES  per-lane flag: that lane had a >= Q or b >= Q

Behaviour:
- Handshake
  - A transfer occurs on a cycle with valid && ready.
  - Output payload stays stable while out_valid && !out_ready.
- Stage registers
  - S1 holds valid v1, mode, tag, raw per-lane results (WIDTH+1 bits) and per-lane err.
  - S2 drives out_*; out_valid = v2.
- Enables
  - en2 = !v2 || out_ready.
  - en1 = !v1 || en2.
  - in_ready = en1, combinational from v1, v2 and out_ready.
  - A bubble in S1 is filled while S2 is stalled. S1 captures a new input only when its contents move to S2 in the same cycle, or when it is empty.
- Stage 1, per lane, captured when en1:
  - add: raw = {0,a} + {0,b}.
  - sub: raw = {0,a} - {0,b}, taken as signed WIDTH+1 bits.
  - err = (a >= Q) || (b >= Q).
  - v1 <= in_valid.
- Stage 2, per lane, captured when en2:
  - add: c = raw >= Q ? raw - Q : raw.
  - sub: c = raw < 0 ? raw + Q : raw.
  - c is truncated to WIDTH bits. v2 <= v1. tag and err are copied from S1.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high.
- Throughput: 1 transaction per cycle.
- Ordering: results leave strictly in acceptance order. Nothing is dropped or duplicated.
- Capacity: 2 transactions. With out_ready held low, in_ready falls once v1 and v2 are both set.
- Simultaneous events: S2 full with out_ready=1 and a new input present means S2 outputs, S1 moves to S2, and the new input enters S1, all in the same cycle.
- Out-of-range operands: err is set and c follows the formulas above exactly. Only one correction step is applied, so c is not guaranteed < Q. No other side effects.
- Lanes: fully independent arithmetic and err. mode, valid and tag are shared across lanes.
- Reset:
  - v1, v2, out_valid = 0.
  - out_c = 0, out_tag = 0, out_err = 0.
  - S1 data = 0.
  - in_ready = 1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight transactions, and no output handshake occurs for them.
- Assertions (verification only): Q < 2^WIDTH; out_c lane < Q whenever the corresponding out_err lane is 0.

Test Plan:
1. LANES=1, out_ready=1. Add a=3, b=4 -> out_c=7, out_err=0, 2 cycles after acceptance. Add a=Q-1, b=Q-1 -> 1073479679.
2. Sub a=5, b=7 -> 1073479679. Sub a=b=123456 -> 0. Sub a=Q-1, b=0 -> 1073479680. Back-to-back inputs with alternating mode, tags 0..15 -> tags return in order, one result per cycle.
3. Backpressure: out_ready=0, offer 3 inputs with tags 1, 2, 3.
   - Tags 1 and 2 are accepted; in_ready=0 while tag 3 waits.
   - out_c and out_tag stay stable while stalled.
   - Raise out_ready -> tags 1, 2, 3 emerge consecutively, none lost.
4. Bubble collapse: input tag A, one idle cycle, then tag B, with out_ready=0 throughout. Both are accepted (B while S2 holds A), and in_ready=0 only after B.
5. Range error: add a=Q, b=0 -> out_err=1, out_c=0. Sub a=0, b=Q -> out_err=1, out_c=0. Valid operands in other lanes (LANES=4) show err=0 and correct results.
6. Reset: assert rst for 1 cycle with 2 transactions in flight -> out_valid=0, out_c=0, out_tag=0 next cycle. No stale result appears, and the next input returns its result after 2 cycles.
